// File: rtl/pb_freq_ctrl.sv
// Push-button frequency-word controller.
// Turns debounced UP/DOWN/SELECT button events into a saturating frequency
// word. Holding a button auto-repeats: the first repeat comes HOLD_CYCLES
// after the initial step, and later repeats come every REPEAT_CYCLES.
// freq_update pulses only when the word actually changes, so PLL
// configuration logic can reload on that pulse alone.
module pb_freq_ctrl #(
  parameter int                FREQ_W        = 16,
  parameter logic [FREQ_W-1:0] FREQ_MIN      = 16'h0000,
  parameter logic [FREQ_W-1:0] FREQ_MAX      = 16'hFFFF,
  parameter logic [FREQ_W-1:0] FREQ_INIT     = 16'h8000,
  parameter int                CNT_W         = 24,
  parameter int                HOLD_CYCLES   = 5_000_000,
  parameter int                REPEAT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up_state,
  input  logic              up_press,
  input  logic              dn_state,
  input  logic              dn_press,
  input  logic              sel_press,
  output logic [FREQ_W-1:0] freq_word,
  output logic [1:0]        step_sel,
  output logic              freq_update,
  output logic              repeating
);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dir_q, dir_d;      // 0 = UP, 1 = DOWN
  logic               do_step;
  logic               step_dn;
  logic               held, opposed;
  logic [FREQ_W:0]    step_val;
  logic [FREQ_W:0]    sum_up;
  logic [FREQ_W-1:0]  word_up, word_dn, word_d;

  // Step size and both saturated candidates, computed one bit wider than
  // the word so an overflow past FREQ_MAX, or an underflow below
  // FREQ_MIN, is caught instead of wrapping.
  always_comb begin
    step_val = (FREQ_W+1)'(1) << {step_sel, 2'b00};
    sum_up   = {1'b0, freq_word} + step_val;
    word_up  = (sum_up > {1'b0, FREQ_MAX}) ? FREQ_MAX : sum_up[FREQ_W-1:0];
    word_dn  = ({1'b0, freq_word} < ({1'b0, FREQ_MIN} + step_val))
               ? FREQ_MIN : (freq_word - step_val[FREQ_W-1:0]);
  end

  // Session FSM: decides when a step fires, and in which direction.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    do_step = 1'b0;
    step_dn = dir_q;
    held    = dir_q ? dn_state : up_state;
    opposed = dir_q ? up_state : dn_state;
    unique case (state_q)
      S_IDLE: begin
        // A press counts only when the other button is completely quiet.
        if (up_press && !dn_press && !dn_state) begin
          do_step = 1'b1;
          step_dn = 1'b0;
          dir_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_HOLD;
        end else if (dn_press && !up_press && !up_state) begin
          do_step = 1'b1;
          step_dn = 1'b1;
          dir_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_HOLD;
        end
      end
      S_HOLD, S_REPEAT: begin
        // A release or an opposing hold ends the session before any step
        // that would fall due on this edge.
        if (!held || opposed) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == ((state_q == S_HOLD) ? HOLD_LAST : REP_LAST)) begin
          do_step = 1'b1;
          cnt_d   = '0;
          state_d = S_REPEAT;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    word_d = do_step ? (step_dn ? word_dn : word_up) : freq_word;
  end

  // State, word and step-size registers. step_sel advances after the step
  // that uses it, so a same-edge press steps by the old size.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      freq_word   <= FREQ_INIT;
      step_sel    <= 2'd0;
      freq_update <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      freq_word   <= word_d;
      step_sel    <= step_sel + {1'b0, sel_press};
      freq_update <= (word_d != freq_word);
    end
  end

  assign repeating = (state_q == S_REPEAT);

endmodule

// File: tb/tb_pb_freq_ctrl.sv
// Bench for pb_freq_ctrl: directed scenarios followed by randomized button
// activity. Every cycle is compared against a session-age reference model.
module tb_pb_freq_ctrl;

  localparam int HOLD = 8;
  localparam int REP  = 4;
  localparam int FMIN = 'h0010;
  localparam int FMAX = 'hFFF0;
  localparam int FINI = 'h8000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        up_state = 1'b0, up_press = 1'b0;
  logic        dn_state = 1'b0, dn_press = 1'b0;
  logic        sel_press = 1'b0;
  logic [15:0] freq_word;
  logic [1:0]  step_sel;
  logic        freq_update;
  logic        repeating;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state. age counts the edges since the session's press.
  int m_word, m_sel, m_age;
  bit m_act, m_dn, m_upd, m_rep;

  pb_freq_ctrl #(
    .FREQ_W(16), .FREQ_MIN(16'h0010), .FREQ_MAX(16'hFFF0), .FREQ_INIT(16'h8000),
    .CNT_W(24), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk), .rst(rst),
    .up_state(up_state), .up_press(up_press),
    .dn_state(dn_state), .dn_press(dn_press),
    .sel_press(sel_press),
    .freq_word(freq_word), .step_sel(step_sel),
    .freq_update(freq_update), .repeating(repeating)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advances the model by one edge, using the inputs the DUT sampled.
  task automatic model_edge();
    int  step, nw;
    bit  fire;
    fire = 0;
    if (rst) begin
      m_word = FINI; m_sel = 0; m_act = 0; m_upd = 0; m_rep = 0; m_age = 0;
      return;
    end
    if (!m_act) begin
      if (up_press && !dn_press && !dn_state) begin
        m_act = 1; m_dn = 0; m_age = 0; fire = 1;
      end else if (dn_press && !up_press && !up_state) begin
        m_act = 1; m_dn = 1; m_age = 0; fire = 1;
      end
    end else begin
      m_age++;
      if (!(m_dn ? dn_state : up_state) || (m_dn ? up_state : dn_state))
        m_act = 0;
      else if (m_age == HOLD || (m_age > HOLD && (m_age - HOLD) % REP == 0))
        fire = 1;
    end
    nw = m_word;
    if (fire) begin
      step = 1 << (4 * m_sel);
      if (m_dn) nw = (m_word - step < FMIN) ? FMIN : m_word - step;
      else      nw = (m_word + step > FMAX) ? FMAX : m_word + step;
    end
    m_upd  = (nw != m_word);
    m_word = nw;
    m_rep  = m_act && (m_age >= HOLD);
    m_sel  = (m_sel + int'(sel_press)) % 4;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("freq_word",   32'(freq_word),   32'(m_word));
    chk("step_sel",    32'(step_sel),    32'(m_sel));
    chk("freq_update", 32'(freq_update), 32'(m_upd));
    chk("repeating",   32'(repeating),   32'(m_rep));
  endtask

  task automatic drv(input logic us, input logic up, input logic ds,
                     input logic dp, input logic sp, input logic r);
    up_state = us; up_press = up; dn_state = ds; dn_press = dp;
    sel_press = sp; rst = r;
    tick();
  endtask

  initial begin
    int upd_cnt;
    logic [15:0] w0;
    m_word = FINI; m_sel = 0; m_age = 0; m_act = 0; m_dn = 0; m_upd = 0; m_rep = 0;
    #2;

    // 1. Reset held for two edges.
    drv(0,0,0,0,0,1);
    drv(0,0,0,0,0,1);
    chk("rst_word", 32'(freq_word), 32'h8000);
    chk("rst_sel",  32'(step_sel),  32'd0);
    chk("rst_upd",  32'(freq_update), 32'd0);
    chk("rst_rep",  32'(repeating), 32'd0);

    // 2. Single tap: press, hold three cycles, release.
    upd_cnt = 0;
    drv(1,1,0,0,0,0);
    chk("tap_word", 32'(freq_word), 32'h8001);
    upd_cnt += int'(freq_update);
    for (int i = 0; i < 2; i++) begin drv(1,0,0,0,0,0); upd_cnt += int'(freq_update); end
    for (int i = 0; i < 4; i++) begin drv(0,0,0,0,0,0); upd_cnt += int'(freq_update); end
    chk("tap_pulses", 32'(upd_cnt), 32'd1);

    // 3. Step select; a same-edge select uses the old step size.
    drv(0,0,0,0,0,1);
    drv(0,0,0,0,1,0);
    drv(0,0,0,0,1,0);
    chk("sel2", 32'(step_sel), 32'd2);
    drv(0,0,1,1,1,0);
    chk("dn_sel_word", 32'(freq_word), 32'h7F00);
    chk("dn_sel_sel",  32'(step_sel),  32'd3);
    drv(0,0,0,0,0,0);

    // 4. Auto-repeat with step 1, release at T+18.
    drv(0,0,0,0,0,1);
    drv(1,1,0,0,0,0);
    for (int i = 1; i <= 17; i++) begin
      drv(1,0,0,0,0,0);
      if (i == 8)  chk("rep_t8",  32'(freq_word), 32'h8002);
      if (i == 12) chk("rep_t12", 32'(freq_word), 32'h8003);
      if (i == 16) chk("rep_t16", 32'(freq_word), 32'h8004);
    end
    chk("rep_on", 32'(repeating), 32'd1);
    drv(0,0,0,0,0,0);
    chk("rep_off",  32'(repeating), 32'd0);
    chk("rep_hold", 32'(freq_word), 32'h8004);

    // 5. Saturation at FREQ_MAX with step 4096, then a conflicting press.
    drv(0,0,0,0,0,1);
    for (int i = 0; i < 3; i++) drv(0,0,0,0,1,0);
    for (int i = 0; i < 7; i++) begin drv(1,1,0,0,0,0); drv(0,0,0,0,0,0); end
    chk("sat_start", 32'(freq_word), 32'hF000);
    drv(1,1,0,0,0,0);
    chk("sat_word", 32'(freq_word), 32'hFFF0);
    chk("sat_upd",  32'(freq_update), 32'd1);
    drv(0,0,0,0,0,0);
    drv(1,1,0,0,0,0);
    chk("sat2_word", 32'(freq_word), 32'hFFF0);
    chk("sat2_upd",  32'(freq_update), 32'd0);
    drv(0,0,0,0,0,0);
    drv(1,1,1,1,0,0);
    chk("conflict_word", 32'(freq_word), 32'hFFF0);
    drv(0,0,0,0,0,0);

    // 6a. Abort REPEAT by holding DOWN as well.
    drv(0,0,0,0,0,1);
    drv(1,1,0,0,0,0);
    for (int i = 0; i < 10; i++) drv(1,0,0,0,0,0);
    chk("ab_rep", 32'(repeating), 32'd1);
    drv(1,0,1,0,0,0);
    chk("ab_off", 32'(repeating), 32'd0);
    w0 = freq_word;
    for (int i = 0; i < 12; i++) drv(1,0,0,0,0,0);
    chk("ab_nostep", 32'(freq_word), 32'(w0));
    drv(0,0,0,0,0,0);

    // 6b. Reset in the middle of REPEAT.
    drv(0,0,1,1,0,0);
    for (int i = 0; i < 10; i++) drv(0,0,1,0,0,0);
    drv(0,0,1,0,0,1);
    chk("mid_rst_word", 32'(freq_word), 32'h8000);
    chk("mid_rst_rep",  32'(repeating), 32'd0);
    drv(0,0,0,0,0,0);

    // Randomized button activity; levels persist so sessions reach REPEAT.
    for (int i = 0; i < 3000; i++) begin
      logic us, ds;
      us = up_state; ds = dn_state;
      if ($urandom_range(15) == 0) us = ~us;
      if ($urandom_range(23) == 0) ds = ~ds;
      drv(us, ($urandom_range(5) == 0), ds, ($urandom_range(7) == 0),
          ($urandom_range(19) == 0), ($urandom_range(399) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
